// File: rtl/ara_xif_result_buffer.sv
// ara_xif_result_buffer: in-order XIF result return; alloc_* reserves slots, res_* completes by ID, flush_* squashes, result_* drains head
module ara_xif_result_buffer #(
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ADDR_DEPTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [ID_WIDTH-1:0]   alloc_id_i,
  input  logic                  alloc_we_i,
  input  logic [4:0]            alloc_rd_i,
  input  logic                  res_valid_i,
  input  logic [ID_WIDTH-1:0]   res_id_i,
  input  logic [XLEN-1:0]       res_data_i,
  input  logic                  res_exc_i,
  input  logic [5:0]            res_exccode_i,
  input  logic                  flush_i,
  input  logic [ID_WIDTH-1:0]   flush_id_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [ID_WIDTH-1:0]   result_id_o,
  output logic [XLEN-1:0]       result_data_o,
  output logic [4:0]            result_rd_o,
  output logic                  result_we_o,
  output logic                  result_exc_o,
  output logic [5:0]            result_exccode_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH:0]   usage_o,
  output logic                  spurious_o
);
  logic [DEPTH-1:0]                alloc_q, alloc_d, done_q, done_d, we_q, we_d, exc_q, exc_d, squash;
  logic [DEPTH-1:0][ID_WIDTH-1:0]  id_q, id_d;
  logic [DEPTH-1:0][4:0]           rd_q, rd_d;
  logic [DEPTH-1:0][XLEN-1:0]      data_q, data_d;
  logic [DEPTH-1:0][5:0]           exccode_q, exccode_d;
  logic [ADDR_DEPTH-1:0]           head_q, head_d, tail_q, tail_d, res_idx, flush_idx;
  logic [ADDR_DEPTH:0]             usage_q, usage_d;
  logic                            spurious_q, spurious_d, res_hit, flush_hit, pop, push;
  always_comb begin
    res_hit = 1'b0;
    res_idx = '0;
    flush_hit = 1'b0;
    flush_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_q[i] && id_q[i] == res_id_i) begin
        res_hit = 1'b1;
        res_idx = ADDR_DEPTH'(i);
      end
      if (flush_i && alloc_q[i] && id_q[i] == flush_id_i) begin
        flush_hit = 1'b1;
        flush_idx = ADDR_DEPTH'(i);
      end
    end
  end
  always_comb begin
    squash = '0;
    for (int i = 0; i < DEPTH; i++)
      squash[i] = flush_hit && alloc_q[i] && (ADDR_DEPTH'(i) - head_q >= flush_idx - head_q);
  end
  assign full_o           = usage_q == (ADDR_DEPTH+1)'(DEPTH);
  assign empty_o          = usage_q == '0;
  assign usage_o          = usage_q;
  assign spurious_o       = spurious_q;
  assign alloc_ready_o    = ~full_o & ~flush_i;
  assign result_valid_o   = alloc_q[head_q] & done_q[head_q] & ~squash[head_q];
  assign result_id_o      = id_q[head_q];
  assign result_data_o    = data_q[head_q];
  assign result_rd_o      = rd_q[head_q];
  assign result_we_o      = we_q[head_q];
  assign result_exc_o     = exc_q[head_q];
  assign result_exccode_o = exccode_q[head_q];
  assign pop              = result_valid_o & result_ready_i;
  assign push             = alloc_valid_i & alloc_ready_o;
  always_comb begin
    alloc_d = alloc_q;
    done_d = done_q;
    we_d = we_q;
    exc_d = exc_q;
    id_d = id_q;
    rd_d = rd_q;
    data_d = data_q;
    exccode_d = exccode_q;
    if (res_valid_i && res_hit && !squash[res_idx]) begin
      done_d[res_idx] = 1'b1;
      data_d[res_idx] = res_data_i;
      exc_d[res_idx] = res_exc_i;
      exccode_d[res_idx] = res_exccode_i;
    end
    if (push) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      id_d[tail_q] = alloc_id_i;
      we_d[tail_q] = alloc_we_i;
      rd_d[tail_q] = alloc_rd_i;
    end
    alloc_d = alloc_d & ~squash;
    if (pop) alloc_d[head_q] = 1'b0;
    head_d = head_q + ADDR_DEPTH'(pop);
    tail_d = flush_hit ? flush_idx : tail_q + ADDR_DEPTH'(push);
    usage_d = flush_hit ? {1'b0, flush_idx - head_d}
                        : usage_q + (ADDR_DEPTH+1)'(push) - (ADDR_DEPTH+1)'(pop);
    spurious_d = (res_valid_i & ~res_hit) | (flush_i & ~empty_o & ~flush_hit);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_q <= '0;
      done_q <= '0;
      we_q <= '0;
      exc_q <= '0;
      id_q <= '0;
      rd_q <= '0;
      data_q <= '0;
      exccode_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      usage_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      done_q <= done_d;
      we_q <= we_d;
      exc_q <= exc_d;
      id_q <= id_d;
      rd_q <= rd_d;
      data_q <= data_d;
      exccode_q <= exccode_d;
      head_q <= head_d;
      tail_q <= tail_d;
      usage_q <= usage_d;
      spurious_q <= spurious_d;
    end
  end
endmodule

// File: doc/ara_xif_result_buffer.md
# ara_xif_result_buffer

- Collects Ara's vector instruction results and returns them in issue order to the scalar core over the CORE-V eXtension Interface (XIF) result channel.
- It is the outbound counterpart of Ara's XIF issue-side instruction buffer.
- A slot is reserved per offloaded instruction at issue. Ara writes each result into its slot by instruction ID, in any order.
- Only the oldest completed slot is presented on a valid/ready handshake. Speculative entries are discarded on flush.

## Interface
Parameters:
- ID_WIDTH, 8, width of XIF instruction ID
- DEPTH, 4, number of result slots; power of two, ≥2
- XLEN, 64, result data width
- ADDR_DEPTH, $clog2(DEPTH), derived slot index width; not to be overridden

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- alloc_valid_i  in  1  reserve slot for a newly issued instruction
- alloc_ready_o  out  1  slot available (= ~full_o & ~flush_i)
- alloc_id_i  in  ID_WIDTH  XIF ID of issued instruction
- alloc_we_i  in  1  instruction writes scalar rd
- alloc_rd_i  in  5  destination register
- res_valid_i  in  1  Ara result write
- res_id_i  in  ID_WIDTH  ID of completing instruction
- res_data_i  in  XLEN  scalar result
- res_exc_i  in  1  instruction raised exception
- res_exccode_i  in  6  exception code
- flush_i  in  1  discard entry flush_id_i and all younger entries
- flush_id_i  in  ID_WIDTH  oldest ID to discard
- result_valid_o  out  1  head result offered to core
- result_ready_i  in  1  core accepts result
- result_id_o / result_data_o / result_rd_o / result_we_o / result_exc_o / result_exccode_o  out  ID_WIDTH/XLEN/5/1/1/6  head slot contents
- full_o  out  1  usage == DEPTH
- empty_o  out  1  usage == 0
- usage_o  out  ADDR_DEPTH+1  occupied slots
- spurious_o  out  1  one-cycle pulse: res or flush ID matched no allocated slot

## Operation
- Slot state: alloc, done, id, we, rd, data, exc, exccode. Pointers head/tail are ADDR_DEPTH bits and wrap modulo DEPTH. usage is ADDR_DEPTH+1 bits.
- Alloc: on alloc_valid_i & alloc_ready_o, write slot[tail] with alloc=1, done=0 and the alloc fields. Then tail+1 and usage+1.
- Result write:
  - ID match is a CAM over slots with alloc=1 and registered state. Outstanding IDs are unique.
  - On a hit, set done=1 and store data/exc/exccode.
  - A second write to a done slot overwrites it.
  - On a miss, drop the write and pulse spurious_o.
- Output:
  - result_valid_o = slot[head].alloc & slot[head].done & ~(flush_i & flush hits head).
  - result_* = slot[head] fields, from registers only. There is no bypass from res_*.
  - Pop on result_valid_o & result_ready_i: clear alloc, head+1, usage−1.
- Flush:
  - Locate slot f holding flush_id_i. Clear alloc for f through tail−1. Set tail=f and usage=(f−head_next) mod 2^(ADDR_DEPTH+1).
  - head_next includes any same-cycle pop.
  - Miss: no state change, pulse spurious_o.
  - flush_i with empty_o: no effect, no pulse.
- Simultaneous events:
  - alloc+pop: usage unchanged, both pointers advance.
  - alloc+flush: alloc blocked by alloc_ready_o.
  - Result write to a slot being flushed: dropped, no spurious pulse.
  - Pop of head while flush targets a younger slot: both take effect.
  - Pop while full: alloc_ready_o stays low that cycle (no pass-through).
- Reset (rst_i high at a clock edge, including mid-transaction):
  - All slots alloc=done=0; head=tail=usage=0.
  - Outputs: result_valid_o=0, result_*=0, full_o=0, empty_o=1, usage_o=0, spurious_o=0, alloc_ready_o=1.

## Timing
- Alloc accepted at edge t → full_o/empty_o/usage_o updated after t. Throughput 1 alloc/cycle.
- Result write at edge t into the head slot → result_valid_o high in cycle t+1. Minimum alloc-to-result-out latency is 2 cycles.
- A result for an ID allocated in the same cycle misses. The issuer guarantees res follows alloc by ≥1 cycle.
- result_valid_o, once high, stays high with stable result_* until accepted. The only exception is flush of the head slot, which drops it in the flush cycle.
- Sustained 1 result/cycle when results are done in order and result_ready_i=1.
- spurious_o is registered and asserts the cycle after the offending input.

## Test plan
- Alloc IDs 3,4,5,6 (DEPTH=4) → full_o=1, alloc_ready_o=0, usage_o=4. Write results for 6,5,4,3 with data 0x66..0x33 → output order 3,4,5,6 with matching data; empty_o=1 at end.
- Alloc 10. Result 10 data 0xAB at edge t, result_ready_i=0 for 3 cycles → result_valid_o high from t+1, result_data_o=0xAB stable. Ready=1 → popped, usage_o=0.
- Alloc 1,2,3,4; results for all; flush_id_i=3 while popping 1 → 1 accepted, slots 3,4 cleared, usage_o=1. Subsequent alloc 7 reuses the wrapped tail slot; output order 2 then 7.
- Result write with res_id_i=99 never allocated → no output change, spurious_o pulses one cycle. Flush of unknown ID on a non-empty buffer behaves the same.
- Ten alloc/pop pairs with 1-cycle spacing → head/tail wrap twice, IDs returned in order, usage_o never exceeds 2.
- Assert rst_i with 3 slots allocated and result_valid_o=1 → next cycle result_valid_o=0, empty_o=1, usage_o=0, alloc_ready_o=1.
